mem_proc_sp_bist: RTL and testbench



---
 rtl/mem_proc_pkg.sv | 30 +++
 rtl/mem_proc_bist_ctrl.sv | 155 +++++++++++++++
 rtl/mem_proc_sp_bist.sv | 93 +++++++++
 tb/tb_mem_proc_sp_bist.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_proc_pkg.sv
// Shared types and constants for the processor memory wrapper with built-in self-test.
package mem_proc_pkg;

    localparam int unsigned DEF_WIDTH = 73;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned MAX_WIDTH = 1024;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0,
        W1,
        R1,
        DRAIN,
        DONE
    } bist_state_e;

    // Alternating ...0101 background; an odd top bit is left at 0.
    function automatic logic [MAX_WIDTH-1:0] alt_pattern(input int unsigned w);
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if ((i < 2 * (w / 2)) && (i % 2 == 0)) begin
                p = p | (MAX_WIDTH'(1) << i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_proc_bist_ctrl.sv
// March BIST sequencer: walks W0/R0/W1/R1 over the array and checks read-back data.
module mem_proc_bist_ctrl
    import mem_proc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(alt_pattern(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rd_data_s1,
    output logic             wr_en_c,
    output logic             rd_en_c,
    output logic [AW-1:0]    addr_c,
    output logic [WIDTH-1:0] wr_data_c,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [AW-1:0]    fail_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    bist_state_e      state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_d, done_d, clear_c;
    logic [WIDTH-1:0] exp_c;

    // Expected data and address ride alongside the array read pipe.
    logic             v1, v2;
    logic [WIDTH-1:0] exp1, exp2, d2;
    logic [AW-1:0]    addr1, addr2;
    logic             mismatch_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy;
        done_d    = done;
        clear_c   = 1'b0;
        wr_en_c   = 1'b0;
        rd_en_c   = 1'b0;
        addr_c    = cnt_q;
        wr_data_c = PATTERN;
        exp_c     = PATTERN;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    clear_c = 1'b1;
                end
            end
            W0: begin
                wr_en_c = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = R0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            R0: begin
                rd_en_c = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = W1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            W1: begin
                wr_en_c   = 1'b1;
                wr_data_c = ~PATTERN;
                if (cnt_q == LAST) begin
                    state_d = R1;
                    cnt_d   = LAST;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            R1: begin
                rd_en_c = 1'b1;
                exp_c   = ~PATTERN;
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - AW'(1);
                end
            end
            DRAIN: begin
                // Two cycles let the last R1 compare land before DONE.
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mismatch_c = v2 && (d2 != exp2);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            exp1      <= '0;
            exp2      <= '0;
            d2        <= '0;
            addr1     <= '0;
            addr2     <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            v1    <= rd_en_c;
            exp1  <= exp_c;
            addr1 <= addr_c;
            v2    <= v1;
            exp2  <= exp1;
            addr2 <= addr1;
            d2    <= rd_data_s1;
            if (clear_c) begin
                fail      <= 1'b0;
                fail_addr <= '0;
            end else if (mismatch_c && !fail) begin
                fail      <= 1'b1;
                fail_addr <= addr2;
            end
        end
    end

endmodule

// File: rtl/mem_proc_sp_bist.sv
// Processor RAM wrapper: 1W/1R array, 2-cycle read pipe with valid, on-clock march BIST.
module mem_proc_sp_bist
    import mem_proc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(alt_pattern(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_wr_en,
    input  logic [AW-1:0]    mem_wr_addr,
    input  logic [WIDTH-1:0] mem_wr_data,
    input  logic             mem_rd_en,
    input  logic [AW-1:0]    mem_rd_addr,
    output logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_rd_valid,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_fail,
    output logic [AW-1:0]    bist_fail_addr
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             bist_wr_en_c, bist_rd_en_c;
    logic [AW-1:0]    bist_addr_c;
    logic [WIDTH-1:0] bist_wr_data_c;

    logic             wr_en_c, rd_en_c, wr_ok_c, rd_ok_c;
    logic [AW-1:0]    wr_addr_c, rd_addr_c;
    logic [WIDTH-1:0] wr_data_c;

    logic [WIDTH-1:0] s1_data;
    logic             s1_func;

    mem_proc_bist_ctrl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .PATTERN (PATTERN)
    ) u_bist (
        .clk        (clk),
        .rst        (rst),
        .start      (bist_start),
        .rd_data_s1 (s1_data),
        .wr_en_c    (bist_wr_en_c),
        .rd_en_c    (bist_rd_en_c),
        .addr_c     (bist_addr_c),
        .wr_data_c  (bist_wr_data_c),
        .busy       (bist_busy),
        .done       (bist_done),
        .fail       (bist_fail),
        .fail_addr  (bist_fail_addr)
    );

    // The BIST owns the array while busy; functional requests are dropped.
    assign wr_en_c   = bist_busy ? bist_wr_en_c   : mem_wr_en;
    assign wr_addr_c = bist_busy ? bist_addr_c    : mem_wr_addr;
    assign wr_data_c = bist_busy ? bist_wr_data_c : mem_wr_data;
    assign rd_en_c   = bist_busy ? bist_rd_en_c   : mem_rd_en;
    assign rd_addr_c = bist_busy ? bist_addr_c    : mem_rd_addr;
    assign wr_ok_c   = 32'(wr_addr_c) < DEPTH;
    assign rd_ok_c   = 32'(rd_addr_c) < DEPTH;

    always_ff @(posedge clk) begin
        if (wr_en_c && wr_ok_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Stage 1 is shared with the BIST compare pipe; stage 2 is functional only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data      <= '0;
            s1_func      <= 1'b0;
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
        end else begin
            if (rd_en_c) begin
                s1_data <= rd_ok_c ? mem[rd_addr_c] : '0;
            end
            s1_func      <= mem_rd_en && !bist_busy;
            mem_rd_valid <= s1_func;
            if (s1_func) begin
                mem_rd_data <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_proc_sp_bist.sv
// Directed bench for mem_proc_sp_bist: functional read/write table plus BIST run sequences.
module tb_mem_proc_sp_bist;

    localparam int unsigned D = 16;
    localparam logic [72:0] P    = 73'({36{2'b01}});
    localparam logic [72:0] NP   = ~P;
    localparam logic [72:0] D73  = 73'h1_2345_6789_ABCD_EF01_23;
    localparam logic [72:0] FLIP = 73'h1 << 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr_en, mem_rd_en, bist_start;
    logic [3:0]  mem_wr_addr, mem_rd_addr;
    logic [72:0] mem_wr_data;
    logic [72:0] mem_rd_data;
    logic        mem_rd_valid, bist_busy, bist_done, bist_fail;
    logic [3:0]  bist_fail_addr;

    logic        s_wr_en, s_rd_en;
    logic [3:0]  s_wr_addr, s_rd_addr;
    logic [72:0] s_wr_data, s_rd_data;
    logic        s_rd_valid, s_busy, s_done, s_fail;
    logic [3:0]  s_fail_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_proc_sp_bist dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_rd_valid   (mem_rd_valid),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr)
    );

    mem_proc_sp_bist #(.DEPTH(12)) dut12 (
        .clk            (clk),
        .rst            (rst),
        .mem_wr_en      (s_wr_en),
        .mem_wr_addr    (s_wr_addr),
        .mem_wr_data    (s_wr_data),
        .mem_rd_en      (s_rd_en),
        .mem_rd_addr    (s_rd_addr),
        .mem_rd_data    (s_rd_data),
        .mem_rd_valid   (s_rd_valid),
        .bist_start     (1'b0),
        .bist_busy      (s_busy),
        .bist_done      (s_done),
        .bist_fail      (s_fail),
        .bist_fail_addr (s_fail_addr)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [72:0] wr_data;
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic        exp_valid;
        logic [72:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_bist(input string tag);
        chk({tag, " busy"},      73'(bist_busy),      73'(1'b0));
        chk({tag, " done"},      73'(bist_done),      73'(1'b0));
        chk({tag, " fail"},      73'(bist_fail),      73'(1'b0));
        chk({tag, " fail_addr"}, 73'(bist_fail_addr), 73'(4'd0));
    endtask

    // One full BIST run from a start pulse, optionally corrupting word 9 after W1.
    task automatic bist_run(input string tag, input bit inject, input bit inflight,
                            input logic exp_fail, input logic [3:0] exp_faddr);
        bist_start  = 1'b1;
        mem_wr_en   = 1'b0;
        mem_rd_en   = inflight;
        mem_rd_addr = 4'd9;
        step();
        bist_start  = 1'b0;
        mem_wr_en   = 1'b1;
        mem_wr_addr = 4'd0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b1;
        chk({tag, " busy at start"}, 73'(bist_busy), 73'(1'b1));
        chk({tag, " done cleared"},  73'(bist_done), 73'(1'b0));
        for (int k = 1; k <= 4 * D + 2; k++) begin
            step();
            if (k == 1) begin
                chk({tag, " inflight valid"}, 73'(mem_rd_valid), 73'(inflight));
                if (inflight) chk({tag, " inflight data"}, mem_rd_data, NP);
            end
            if (k == 2 || k == 40) chk({tag, " valid during run"}, 73'(mem_rd_valid), 73'(1'b0));
            if (k == 30) bist_start = 1'b1;
            if (k == 31) bist_start = 1'b0;
            if (inject && k == 3 * D) dut.mem[9] = NP ^ FLIP;
            if (k == 4 * D + 1) begin
                chk({tag, " busy before done"}, 73'(bist_busy), 73'(1'b1));
                chk({tag, " done early"},       73'(bist_done), 73'(1'b0));
            end
        end
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        chk({tag, " done"},      73'(bist_done),      73'(1'b1));
        chk({tag, " busy end"},  73'(bist_busy),      73'(1'b0));
        chk({tag, " fail"},      73'(bist_fail),      73'(exp_fail));
        chk({tag, " fail_addr"}, 73'(bist_fail_addr), 73'(exp_faddr));
    endtask

    task automatic read_back(input string tag, input logic [3:0] a, input logic [72:0] exp);
        mem_rd_en   = 1'b1;
        mem_rd_addr = a;
        step();
        mem_rd_en = 1'b0;
        step();
        chk({tag, " valid"}, 73'(mem_rd_valid), 73'(1'b1));
        chk({tag, " data"},  mem_rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd3, D73,        1'b0, 4'd0, 1'b0, 73'd0};
        vecs[1]  = '{1'b0, 4'd0, 73'd0,      1'b1, 4'd3, 1'b0, 73'd0};
        vecs[2]  = '{1'b1, 4'd5, 73'h55,     1'b0, 4'd0, 1'b1, D73};
        vecs[3]  = '{1'b0, 4'd0, 73'd0,      1'b0, 4'd0, 1'b0, D73};
        vecs[4]  = '{1'b1, 4'd5, 73'hAA,     1'b1, 4'd5, 1'b0, D73};
        vecs[5]  = '{1'b0, 4'd0, 73'd0,      1'b1, 4'd5, 1'b1, 73'h55};
        vecs[6]  = '{1'b1, 4'd2, 73'h222,    1'b0, 4'd0, 1'b1, 73'hAA};
        vecs[7]  = '{1'b1, 4'd4, 73'h444,    1'b0, 4'd0, 1'b0, 73'hAA};
        vecs[8]  = '{1'b0, 4'd0, 73'd0,      1'b1, 4'd2, 1'b0, 73'hAA};
        vecs[9]  = '{1'b0, 4'd0, 73'd0,      1'b1, 4'd3, 1'b1, 73'h222};
        vecs[10] = '{1'b0, 4'd0, 73'd0,      1'b1, 4'd4, 1'b1, D73};
        vecs[11] = '{1'b0, 4'd0, 73'd0,      1'b0, 4'd0, 1'b1, 73'h444};
        vecs[12] = '{1'b0, 4'd0, 73'd0,      1'b0, 4'd0, 1'b0, 73'h444};

        rst = 1'b1;
        mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        mem_rd_en = 1'b0; mem_rd_addr = '0; bist_start = 1'b0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_en = 1'b0; s_rd_addr = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset valid", 73'(mem_rd_valid), 73'(1'b0));
        chk("reset data",  mem_rd_data, 73'd0);
        chk_idle_bist("reset");

        for (int i = 0; i < 13; i++) begin
            mem_wr_en   = vecs[i].wr_en;
            mem_wr_addr = vecs[i].wr_addr;
            mem_wr_data = vecs[i].wr_data;
            mem_rd_en   = vecs[i].rd_en;
            mem_rd_addr = vecs[i].rd_addr;
            step();
            chk($sformatf("vec%0d valid", i), 73'(mem_rd_valid), 73'(vecs[i].exp_valid));
            chk($sformatf("vec%0d data", i),  mem_rd_data, vecs[i].exp_data);
        end
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;

        // DEPTH=12 build: out-of-range write dropped, read returns zero with valid.
        s_wr_en = 1'b1; s_wr_addr = 4'd13; s_wr_data = '1;
        step();
        s_wr_addr = 4'd2; s_wr_data = 73'h3;
        step();
        s_wr_en = 1'b0; s_rd_en = 1'b1; s_rd_addr = 4'd13;
        step();
        s_rd_addr = 4'd2;
        step();
        s_rd_en = 1'b0;
        chk("oor read valid", 73'(s_rd_valid), 73'(1'b1));
        chk("oor read data",  s_rd_data, 73'd0);
        step();
        chk("d12 read valid", 73'(s_rd_valid), 73'(1'b1));
        chk("d12 read data",  s_rd_data, 73'h3);

        bist_run("run1", 1'b0, 1'b0, 1'b0, 4'd0);
        read_back("post run1 a0",  4'd0,  NP);
        read_back("post run1 a9",  4'd9,  NP);
        read_back("post run1 a15", 4'd15, NP);

        bist_run("fault", 1'b1, 1'b1, 1'b1, 4'd9);
        read_back("post fault a9", 4'd9, NP ^ FLIP);

        // Abort a run with reset, then rerun cleanly.
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        for (int k = 1; k < 20; k++) step();
        chk("mid-run busy", 73'(bist_busy), 73'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_bist("abort");
        chk("abort valid", 73'(mem_rd_valid), 73'(1'b0));
        bist_run("rerun", 1'b0, 1'b0, 1'b0, 4'd0);
        read_back("post rerun a9", 4'd9, NP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
